// File: rtl/capture_ram.sv
// Response-capture RAM: auto-incrementing write pointer, fill count, sticky overflow, registered read port.
// Optional build macro CAPTURE_SKIP_ZERO_EN drops all-zero response words (an idle bus reads as 0).
module capture_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter bit WRAP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              filtered;
    logic              wr_req;
    logic              accept;

`ifdef CAPTURE_SKIP_ZERO_EN
    assign filtered = (data_in == '0);
`else
    assign filtered = 1'b0;
`endif

    assign full   = (count == DEPTH_C);
    assign wr_req = wr && !clr && !filtered;
    // In wrap mode a full RAM keeps accepting and overwrites the oldest word.
    assign accept = wr_req && (!full || WRAP);

    // Memory is deliberately not reset; contents survive rst and clr.
    always_ff @(posedge clk) begin
        if (accept && !rst)
            mem[wr_addr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_out <= '0;
        else
            data_out <= mem[rd_addr];   // read-first against a same-edge write
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_addr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_req && full)
                overflow <= 1'b1;
            if (accept) begin
                wr_addr <= wr_addr + 1'b1;
                if (!full)
                    count <= count + 1'b1;
            end
        end
    end
endmodule
